// File: rtl/pipeline_debug_pkg.sv
// Shared constants for the pipeline debug sequencer: command bytes and FSM state encoding.
package pipeline_debug_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_RST  = 8'h58;
    localparam logic [7:0] CMD_HALT = 8'h48;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_LOAD_LEN  = 3'd1;
    localparam state_t ST_LOAD_BYTE = 3'd2;
    localparam state_t ST_RUN       = 3'd3;
    localparam state_t ST_STEP      = 3'd4;
    localparam state_t ST_DUMP_REQ  = 3'd5;
    localparam state_t ST_DUMP_WAIT = 3'd6;
    localparam state_t ST_RST_PIPE  = 3'd7;

endpackage

// File: rtl/debug_word_packer.sv
// Assembles received bytes MSB-first into a word; word_valid pulses the cycle after the last byte.
module debug_word_packer #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_WORD = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               shift,
    input  logic [NB_DATA-1:0] data_byte,
    output logic [NB_WORD-1:0] word,
    output logic               word_valid
);

    localparam int unsigned NB_BYTES = NB_WORD / NB_DATA;
    localparam int unsigned NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    logic [NB_IDX-1:0]  byte_idx;
    logic [NB_WORD-1:0] word_reg;
    logic               valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= '0;
            word_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (clear) begin
                byte_idx <= '0;
                word_reg <= '0;
            end else if (shift) begin
                word_reg <= {word_reg[NB_WORD-NB_DATA-1:0], data_byte};
                if (byte_idx == NB_IDX'(NB_BYTES - 1)) begin
                    byte_idx  <= '0;
                    valid_reg <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

    assign word       = word_reg;
    assign word_valid = valid_reg;

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Command sequencer between UART receive and the pipeline: load, run, step, reset, dump handshake.
// Optional run watchdog enabled by defining PIPELINE_DEBUG_TIMEOUT_EN.
module pipeline_debug_ctrl
    import pipeline_debug_pkg::*;
#(
    parameter int unsigned NB_DATA     = 8,
    parameter int unsigned NB_INSTR    = 32,
    parameter int unsigned NB_ADDR     = 32,
    parameter int unsigned NB_CYCLES   = 32,
    parameter int unsigned RUN_TIMEOUT = 1_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_done,
    input  logic                 i_end,
    input  logic                 i_dump_done,
    output logic                 o_reset_pipeline,
    output logic                 o_stop,
    output logic                 o_write_instruction_mem,
    output logic [NB_ADDR-1:0]   o_instruction_mem_addr,
    output logic [NB_INSTR-1:0]  o_instruction_mem_data,
    output logic                 o_dump_start,
    output logic                 o_busy,
    output logic                 o_error,
    output logic [NB_CYCLES-1:0] o_cycle_count
);

    state_t               state, state_next;
    logic [NB_ADDR-1:0]   addr;
    logic [NB_DATA-1:0]   words_left;
    logic [NB_CYCLES-1:0] cycle_count;
    logic                 stop, reset_pipeline, dump_start, busy, error;
    logic                 error_next, load_start, load_shift, clear_count, timeout;
    logic                 word_valid;
    logic [NB_INSTR-1:0]  word;

    debug_word_packer #(
        .NB_DATA (NB_DATA),
        .NB_WORD (NB_INSTR)
    ) u_packer (
        .clk        (i_clk),
        .rst_n      (i_reset),
        .clear      (load_start),
        .shift      (load_shift),
        .data_byte  (i_rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

`ifdef PIPELINE_DEBUG_TIMEOUT_EN
    localparam int unsigned NB_WDOG = $clog2(RUN_TIMEOUT + 1);
    logic [NB_WDOG-1:0] wdog;

    // Counter is held at zero outside RUN, so it restarts on every RUN entry.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)               wdog <= '0;
        else if (state != ST_RUN)   wdog <= '0;
        else if (!timeout)          wdog <= wdog + 1'b1;
    end

    assign timeout = (state == ST_RUN) && (wdog == NB_WDOG'(RUN_TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        error_next  = 1'b0;
        load_start  = 1'b0;
        load_shift  = 1'b0;
        clear_count = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: state_next = ST_LOAD_LEN;
                        CMD_RUN:  state_next = i_end ? ST_DUMP_REQ : ST_RUN;
                        CMD_STEP: state_next = i_end ? ST_DUMP_REQ : ST_STEP;
                        CMD_RST: begin
                            state_next  = ST_RST_PIPE;
                            clear_count = 1'b1;
                        end
                        default:  error_next = 1'b1;
                    endcase
                end
            end
            ST_LOAD_LEN: begin
                if (i_rx_done) begin
                    if (i_rx_data == '0) begin
                        error_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        load_start = 1'b1;
                        state_next = ST_LOAD_BYTE;
                    end
                end
            end
            ST_LOAD_BYTE: begin
                // Bytes keep shifting during the write cycle of the previous word.
                load_shift = i_rx_done;
                if (word_valid && words_left == NB_DATA'(1)) begin
                    clear_count = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (i_end || (i_rx_done && i_rx_data == CMD_HALT)) begin
                    state_next = ST_DUMP_REQ;
                end else if (timeout) begin
                    error_next = 1'b1;
                    state_next = ST_DUMP_REQ;
                end
            end
            ST_STEP:      state_next = ST_DUMP_REQ;
            ST_DUMP_REQ:  state_next = ST_DUMP_WAIT;
            ST_DUMP_WAIT: if (i_dump_done) state_next = ST_IDLE;
            ST_RST_PIPE:  state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state          <= ST_IDLE;
            addr           <= '0;
            words_left     <= '0;
            cycle_count    <= '0;
            stop           <= 1'b1;
            reset_pipeline <= 1'b0;
            dump_start     <= 1'b0;
            busy           <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= state_next;
            stop           <= !(state_next == ST_RUN || state_next == ST_STEP);
            reset_pipeline <= (state_next == ST_RST_PIPE);
            dump_start     <= (state_next == ST_DUMP_REQ);
            busy           <= (state_next != ST_IDLE);
            error          <= error_next;

            if (load_start) begin
                addr       <= '0;
                words_left <= i_rx_data;
            end else if (word_valid) begin
                addr       <= addr + NB_ADDR'(4);
                words_left <= words_left - 1'b1;
            end

            if (clear_count)                    cycle_count <= '0;
            else if (!stop && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
        end
    end

    assign o_reset_pipeline        = reset_pipeline;
    assign o_stop                  = stop;
    assign o_write_instruction_mem = word_valid;
    assign o_instruction_mem_addr  = addr;
    assign o_instruction_mem_data  = word;
    assign o_dump_start            = dump_start;
    assign o_busy                  = busy;
    assign o_error                 = error;
    assign o_cycle_count           = cycle_count;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Self-checking bench for pipeline_debug_ctrl; build with PIPELINE_DEBUG_TIMEOUT_EN to exercise the watchdog.
module tb_pipeline_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        end_i = 1'b0;
    logic        dump_done = 1'b0;

    logic        o_reset_pipeline, o_stop, o_write_instruction_mem;
    logic [31:0] o_instruction_mem_addr, o_instruction_mem_data, o_cycle_count;
    logic        o_dump_start, o_busy, o_error;

    int errors = 0;
    int checks = 0;

    // Event tallies from the output monitor; expectations come from the tests themselves.
    int n_write = 0, n_dump = 0, n_err = 0, n_rstp = 0, n_run = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    logic [31:0] exp_count = 0;
    logic [31:0] lw [0:15];
    int          gap_max = 0;

    always #5 clk = ~clk;

    pipeline_debug_ctrl #(
        .NB_DATA     (8),
        .NB_INSTR    (32),
        .NB_ADDR     (32),
        .NB_CYCLES   (32),
        .RUN_TIMEOUT (100)
    ) dut (
        .i_clk                   (clk),
        .i_reset                 (rst_n),
        .i_rx_data               (rx_data),
        .i_rx_done               (rx_done),
        .i_end                   (end_i),
        .i_dump_done             (dump_done),
        .o_reset_pipeline        (o_reset_pipeline),
        .o_stop                  (o_stop),
        .o_write_instruction_mem (o_write_instruction_mem),
        .o_instruction_mem_addr  (o_instruction_mem_addr),
        .o_instruction_mem_data  (o_instruction_mem_data),
        .o_dump_start            (o_dump_start),
        .o_busy                  (o_busy),
        .o_error                 (o_error),
        .o_cycle_count           (o_cycle_count)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_write_instruction_mem) begin
                n_write++;
                wr_addr_q.push_back(o_instruction_mem_addr);
                wr_data_q.push_back(o_instruction_mem_data);
            end
            if (o_dump_start)     n_dump++;
            if (o_error)          n_err++;
            if (o_reset_pipeline) n_rstp++;
            if (!o_stop)          n_run++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got hang want finish");
        $fatal(1, "bench timeout");
    end

    // Called at a falling edge; the byte is presented across exactly one rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    function automatic logic [7:0] noise_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'h48) b = 8'h00;
        return b;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (o_busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, want 0", name, o_busy, budget);
        end
        @(negedge clk);
    endtask

    task automatic finish_dump(input string name);
        int k = 0;
        int p0 = n_rstp;
        while (!o_stop && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        if ($urandom_range(0, 1) == 1) send_byte(8'h58);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_in_dump: got %b want 1", name, o_busy);
        end
        dump_done = 1'b1;
        @(negedge clk);
        dump_done = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after_done: got %b want 0", name, o_busy);
        end
        @(negedge clk);
        checks++;
        if (n_rstp != p0) begin
            errors++;
            $display("FAIL %s_byte_in_dump_ignored: reset pulses got %0d want %0d", name, n_rstp, p0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_done = 1'b0;
        end_i = 1'b0;
        dump_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_count = 0;
        checks++;
        if (o_stop !== 1'b1) begin
            errors++;
            $display("FAIL reset_stop: got %b want 1", o_stop);
        end
        checks++;
        if ({o_reset_pipeline, o_write_instruction_mem, o_dump_start, o_busy, o_error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 00000",
                     {o_reset_pipeline, o_write_instruction_mem, o_dump_start, o_busy, o_error});
        end
        checks++;
        if (o_instruction_mem_addr !== 32'h0 || o_instruction_mem_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_bus: got %h/%h want 0/0", o_instruction_mem_addr,
                     o_instruction_mem_data);
        end
        checks++;
        if (o_cycle_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", o_cycle_count);
        end
    endtask

    task automatic do_load(input string name, input int n);
        int w0 = n_write;
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'h4C);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int b = 3; b >= 0; b--) begin
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
                send_byte(8'(lw[i] >> (8 * b)));
            end
        end
        wait_idle(name, 20);
        exp_count = 0;
        checks++;
        if (n_write - w0 != n) begin
            errors++;
            $display("FAIL %s_write_count: got %0d want %0d", name, n_write - w0, n);
        end
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== 32'(4 * i) || wr_data_q[i] !== lw[i]) begin
                errors++;
                $display("FAIL %s_word%0d: got %h@%h want %h@%h", name, i, wr_data_q[i],
                         wr_addr_q[i], lw[i], 32'(4 * i));
            end
        end
        checks++;
        if (o_cycle_count !== exp_count) begin
            errors++;
            $display("FAIL %s_count: got %0d want %0d", name, o_cycle_count, exp_count);
        end
    endtask

    task automatic test_load_fixed();
        lw[0] = 32'h20010005;
        lw[1] = 32'h00000000;
        gap_max = 0;
        do_load("load_fixed", 2);
    endtask

    task automatic test_step();
        int r0 = n_run;
        int d0 = n_dump;
        end_i = 1'b0;
        send_byte(8'h53);
        // A done strobe while the request is still out must not end the dump.
        @(negedge clk);
        dump_done = 1'b1;
        @(negedge clk);
        dump_done = 1'b0;
        exp_count = exp_count + 1;
        finish_dump("step");
        checks++;
        if (n_run - r0 != 1) begin
            errors++;
            $display("FAIL step_run_cycles: got %0d want 1", n_run - r0);
        end
        checks++;
        if (n_dump - d0 != 1) begin
            errors++;
            $display("FAIL step_dumps: got %0d want 1", n_dump - d0);
        end
        checks++;
        if (o_cycle_count !== exp_count) begin
            errors++;
            $display("FAIL step_count: got %0d want %0d", o_cycle_count, exp_count);
        end
    endtask

    // mode 0: stop on i_end, 1: stop on 'H', 2: both on the same edge
    task automatic test_run(input string name, input int len, input int mode);
        int r0 = n_run;
        int d0 = n_dump;
        int e0 = n_err;
        end_i = 1'b0;
        send_byte(8'h52);
        for (int k = 1; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                rx_data = noise_byte();
                rx_done = 1'b1;
            end
            @(negedge clk);
            rx_done = 1'b0;
        end
        if (mode != 1) end_i = 1'b1;
        if (mode != 0) begin
            rx_data = 8'h48;
            rx_done = 1'b1;
        end
        @(negedge clk);
        rx_done = 1'b0;
        checks++;
        if (o_stop !== 1'b1) begin
            errors++;
            $display("FAIL %s_stop_edge: got %b want 1", name, o_stop);
        end
        exp_count = exp_count + 32'(len);
        finish_dump(name);
        checks++;
        if (n_run - r0 != len) begin
            errors++;
            $display("FAIL %s_run_cycles: got %0d want %0d", name, n_run - r0, len);
        end
        checks++;
        if (n_dump - d0 != 1 || n_err != e0) begin
            errors++;
            $display("FAIL %s_dump_err: got dumps=%0d errs=%0d want 1/0", name, n_dump - d0,
                     n_err - e0);
        end
        checks++;
        if (o_cycle_count !== exp_count) begin
            errors++;
            $display("FAIL %s_count: got %0d want %0d", name, o_cycle_count, exp_count);
        end
    endtask

    task automatic test_dump_only(input string name, input logic [7:0] cmd);
        int r0 = n_run;
        int d0 = n_dump;
        end_i = 1'b1;
        send_byte(cmd);
        finish_dump(name);
        checks++;
        if (n_run - r0 != 0 || n_dump - d0 != 1) begin
            errors++;
            $display("FAIL %s: got run=%0d dumps=%0d want 0/1", name, n_run - r0, n_dump - d0);
        end
        checks++;
        if (o_cycle_count !== exp_count) begin
            errors++;
            $display("FAIL %s_count: got %0d want %0d", name, o_cycle_count, exp_count);
        end
    endtask

    task automatic test_errors();
        int e0 = n_err;
        int w0 = n_write;
        int p0 = n_rstp;
        int r0 = n_run;
        int n_bad = 2;
        logic [7:0] b;
        send_byte(8'h7A);
        repeat (2) @(negedge clk);
        checks++;
        if (n_err - e0 != 1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL err_bad_cmd: got errs=%0d busy=%b want 1/0", n_err - e0, o_busy);
        end
        send_byte(8'h4C);
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (n_err - e0 != 2 || n_write != w0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL err_zero_len: got errs=%0d writes=%0d busy=%b want 2/0/0", n_err - e0,
                     n_write - w0, o_busy);
        end
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            if (b != 8'h4C && b != 8'h52 && b != 8'h53 && b != 8'h58) begin
                send_byte(b);
                n_bad++;
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n_err - e0 != n_bad) begin
            errors++;
            $display("FAIL err_random_bytes: got %0d want %0d", n_err - e0, n_bad);
        end
        send_byte(8'h58);
        repeat (2) @(negedge clk);
        exp_count = 0;
        checks++;
        if (n_rstp - p0 != 1 || n_run != r0) begin
            errors++;
            $display("FAIL pipe_reset: got pulses=%0d run=%0d want 1/0", n_rstp - p0, n_run - r0);
        end
        checks++;
        if (o_cycle_count !== exp_count || o_stop !== 1'b1) begin
            errors++;
            $display("FAIL pipe_reset_state: got count=%0d stop=%b want 0/1", o_cycle_count, o_stop);
        end
    endtask

    task automatic test_reset_mid_load();
        int w0 = n_write;
        send_byte(8'h4C);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_stop !== 1'b1 || o_instruction_mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midload_async_reset: got busy=%b stop=%b addr=%h want 0/1/0", o_busy,
                     o_stop, o_instruction_mem_addr);
        end
        checks++;
        if (n_write - w0 != 1) begin
            errors++;
            $display("FAIL midload_first_word: got %0d writes want 1", n_write - w0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_count = 0;
        lw[0] = 32'hDEADBEEF;
        gap_max = 1;
        do_load("reload", 1);
    endtask

`ifdef PIPELINE_DEBUG_TIMEOUT_EN
    task automatic test_timeout();
        int r0 = n_run;
        int d0 = n_dump;
        int e0 = n_err;
        end_i = 1'b0;
        send_byte(8'h52);
        finish_dump("timeout");
        exp_count = exp_count + 100;
        checks++;
        if (n_run - r0 != 100 || n_err - e0 != 1 || n_dump - d0 != 1) begin
            errors++;
            $display("FAIL timeout: got run=%0d errs=%0d dumps=%0d want 100/1/1", n_run - r0,
                     n_err - e0, n_dump - d0);
        end
        checks++;
        if (o_cycle_count !== exp_count) begin
            errors++;
            $display("FAIL timeout_count: got %0d want %0d", o_cycle_count, exp_count);
        end
    endtask
`endif

    task automatic test_random_mix();
        int n;
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    n = $urandom_range(1, 5);
                    for (int i = 0; i < n; i++) lw[i] = $urandom;
                    gap_max = $urandom_range(0, 2);
                    do_load("rand_load", n);
                end
                1: test_run("rand_run", $urandom_range(1, 60), $urandom_range(0, 2));
                2: test_step();
                default: begin
                    end_i = 1'b0;
                    send_byte(8'h58);
                    repeat (2) @(negedge clk);
                    exp_count = 0;
                    checks++;
                    if (o_cycle_count !== exp_count) begin
                        errors++;
                        $display("FAIL rand_pipe_reset_count: got %0d want 0", o_cycle_count);
                    end
                end
            endcase
            end_i = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_load_fixed();
        test_step();
        test_errors();
        test_run("run37", 37, 0);
        test_dump_only("dump_only_run", 8'h52);
        test_dump_only("dump_only_step", 8'h53);
        end_i = 1'b0;
        test_run("run_halt", 12, 1);
        test_run("run_both", 5, 2);
        test_random_mix();
        test_reset_mid_load();
`ifdef PIPELINE_DEBUG_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_debug_ctrl.md
Name: pipeline_debug_ctrl

Overview:
Command-driven sequencer between the UART receive path and the pipeline.
- Decodes single-byte commands from uart_rx.
- Loads program words into instruction memory.
- Runs or single-steps the pipeline by driving its stop input.
- Pipeline reset: pulses the pipeline reset on command.
- Stage dump: after every run or step, hands off to the stage-dump/transmit engine via a start/done handshake.

Parameters:
NB_DATA, 8, UART byte width
NB_INSTR, 32, instruction word width (4 bytes, MSB first)
NB_ADDR, 32, instruction memory byte address width
NB_CYCLES, 32, executed-cycle counter width
RUN_TIMEOUT, 1_000_000, watchdog limit in cycles (used only with the optional feature)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  NB_DATA  received byte, valid while i_rx_done=1
i_rx_done  in  1  one-cycle strobe per received byte
i_end  in  1  pipeline has retired its halt instruction (level)
i_dump_done  in  1  one-cycle strobe: dump engine has finished transmitting
o_reset_pipeline  out  1  one-cycle pipeline reset pulse
o_stop  out  1  1 = pipeline frozen
o_write_instruction_mem  out  1  one-cycle instruction memory write strobe
o_instruction_mem_addr  out  NB_ADDR  write byte address
o_instruction_mem_data  out  NB_INSTR  write data
o_dump_start  out  1  one-cycle request to the dump engine
o_busy  out  1  state != IDLE
o_error  out  1  one-cycle pulse on a protocol error
o_cycle_count  out  NB_CYCLES  cycles executed since the last pipeline reset or program load

Behaviour:
- All outputs are registered.
- Reset values: o_stop=1, o_cycle_count=0, and every other output 0. State=IDLE.
- Commands (accepted only in IDLE): 'L' 0x4C load, 'R' 0x52 run, 'S' 0x53 step, 'X' 0x58 pipeline reset.
- Any other byte in IDLE: o_error pulses for 1 cycle; state stays IDLE.
- States: IDLE, LOAD_LEN, LOAD_BYTE, RUN, STEP, DUMP_REQ, DUMP_WAIT, RST_PIPE.
- LOAD_LEN: the next byte is N, the word count.
  - N=0: o_error pulse, return to IDLE.
  - Otherwise: clear word address to 0 and byte index to 0, go to LOAD_BYTE.
- LOAD_BYTE: shift each received byte into the word register, MSB first.
  - On the 4th byte, the following cycle drives o_write_instruction_mem=1 with the current address and assembled word. Address then advances by 4.
  - No separate write state, so a byte arriving during the write cycle is still captured.
  - After word N is written: o_cycle_count=0, return to IDLE. Max address 4*254=0x3F8, so no wrap.
- 'R' with i_end=1: no execution; go directly to DUMP_REQ.
- 'R' with i_end=0: o_stop=0 from the next cycle; state RUN.
  - RUN ends at the first edge where i_end=1, or where byte 'H' 0x48 is received. That edge sets o_stop=1; go to DUMP_REQ.
  - All other bytes received in RUN are ignored.
- 'S' with i_end=1: same as 'R' with i_end=1 (dump only).
- 'S' otherwise: o_stop=0 for exactly one cycle (STEP), then o_stop=1 and go to DUMP_REQ.
- o_cycle_count increments on every cycle with o_stop=0 and saturates at all-ones.
- DUMP_REQ: o_dump_start=1 for one cycle, then DUMP_WAIT.
  - i_dump_done is ignored during DUMP_REQ.
  - In DUMP_WAIT, i_dump_done returns the block to IDLE.
  - Bytes received during DUMP_REQ/DUMP_WAIT are ignored.
- 'X': RST_PIPE for one cycle with o_reset_pipeline=1; o_cycle_count=0; o_stop stays 1; then IDLE.
- Asynchronous reset mid-operation (including mid-load):
  - All state returns to reset values immediately and a partial word is discarded.
  - Words already written stay in instruction memory.
- Simultaneous i_end and 'H' in RUN: a single stop/dump occurs, no error.

Optional Feature:
Macro PIPELINE_DEBUG_TIMEOUT_EN.
- Defined: a watchdog counter clears on RUN entry and counts RUN cycles. On reaching RUN_TIMEOUT it sets o_stop=1, pulses o_error for 1 cycle and goes to DUMP_REQ.
- Not defined: no watchdog logic; RUN ends only on i_end or 'H'.

Decomposition:
- Package pipeline_debug_pkg: command byte constants (CMD_LOAD, CMD_RUN, CMD_STEP, CMD_RST, CMD_HALT), state enumeration and its width.
- Sub-module debug_word_packer: byte-to-word shift register with byte index and a word-valid strobe. The FSM, address counter, cycle counter and watchdog stay in pipeline_debug_ctrl.

Test Plan:
1. Reset release -> o_stop=1; all other outputs 0; o_busy=0.
2. Send 0x4C 0x02 then 0x20,0x01,0x00,0x05, 0x00,0x00,0x00,0x00 -> writes addr 0x0 data 0x20010005, then addr 0x4 data 0x00000000. Exactly 2 write strobes; o_cycle_count=0.
3. 'S' with i_end=0 -> o_stop low for exactly 1 cycle; o_cycle_count=1; one o_dump_start; o_busy until i_dump_done.
4. 'R', then i_end raised after 37 cycles -> o_stop=1 on the next edge; o_cycle_count=37; one dump. A further 'R' with i_end=1 -> dump only, count unchanged.
5. 0x7A in IDLE, and 'L' followed by 0x00 -> o_error pulse in each case, no writes; then 'X' -> one o_reset_pipeline pulse and count cleared.
6. Reset asserted after 2 bytes of a word, then re-load 1 word 0xDEADBEEF -> written at addr 0x0 with no stale bytes. With PIPELINE_DEBUG_TIMEOUT_EN and RUN_TIMEOUT=100, 'R' with i_end=0 -> stop after 100 cycles, o_error pulse, dump.
